// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with an APB register front end.
// Bytes arrive on rx_strobe and leave through RXDATA reads; irq tracks fill level.
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  APB_PRESETn,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [3:0]            pstb,
    output logic                  pready,
    output logic                  perr,
    input  logic                  rx_strobe,
    input  logic [7:0]            rx_data,
    output logic                  irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
    logic          r_irq_en;
    logic [7:0]    r_thr;
    logic          r_irq;

    logic [3:0]    w_off;
    logic          w_acc;
    logic          w_valid;
    logic          w_err;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_st;
    logic          w_wr_ct;
    logic          w_flush;
    logic          w_push;
    logic          w_drop;
    logic [CW-1:0] w_count_nx;
    logic          w_ovf_nx;
    logic          w_irq_en_nx;
    logic [7:0]    w_thr_nx;
    logic          w_irq_nx;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_off   = paddr[3:0];
    assign w_acc   = psel & penable;
    assign w_valid = (w_off == 4'h0) | (w_off == 4'h4) | (w_off == 4'h8);
    assign w_err   = w_acc & (~w_valid | (pwrite & (w_off == 4'h0)));
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = w_acc & ~pwrite & (w_off == 4'h0) & ~w_empty;
    assign w_wr_st = w_acc & pwrite & (w_off == 4'h4);
    assign w_wr_ct = w_acc & pwrite & (w_off == 4'h8);
    assign w_flush = w_wr_ct & pstb[2] & pwdata[16];
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign w_push  = rx_strobe & ~w_flush & (~w_full | w_pop);
    assign w_drop  = rx_strobe & ~w_flush & w_full & ~w_pop;
    assign w_unused = ^{paddr[ADDR_WIDTH-1:4], pwdata[DATA_WIDTH-1:17],
                        pwdata[7:1], pstb[3]};

    // Next-state values for count, flags and control fields
    always_comb begin
        w_count_nx = r_count;
        if (w_flush)
            w_count_nx = '0;
        else if (w_push & ~w_pop)
            w_count_nx = r_count + CW'(1);
        else if (w_pop & ~w_push)
            w_count_nx = r_count - CW'(1);
        w_ovf_nx = r_ovf;
        if (w_wr_st & pstb[1] & pwdata[11])
            w_ovf_nx = 1'b0;
        if (w_drop)
            w_ovf_nx = 1'b1;
        w_irq_en_nx = r_irq_en;
        if (w_wr_ct & pstb[0])
            w_irq_en_nx = pwdata[0];
        w_thr_nx = r_thr;
        if (w_wr_ct & pstb[1])
            w_thr_nx = (pwdata[15:8] == 8'h00) ? 8'h01 : pwdata[15:8];
    end

    assign w_irq_nx = w_irq_en_nx &
                      ((32'(w_count_nx) >= 32'(w_thr_nx)) | w_ovf_nx);

    // Read mux; error accesses and writes return zero
    always_comb begin
        w_rdata = 32'h0;
        if (w_acc & ~pwrite & ~w_err) begin
            case (w_off)
                4'h0:    w_rdata = w_empty ? 32'h8000_0000
                                           : {24'h0, r_mem[r_rptr]};
                4'h4:    w_rdata = {19'h0, r_irq, r_ovf, w_full, w_empty,
                                    9'(r_count)};
                4'h8:    w_rdata = {15'h0, 1'b0, r_thr, 7'h0, r_irq_en};
                default: w_rdata = 32'h0;
            endcase
        end
    end

    assign prdata = APB_PRESETn ? DATA_WIDTH'(w_rdata) : '0;
    assign pready = APB_PRESETn & w_acc;
    assign perr   = APB_PRESETn & w_err;
    assign irq    = r_irq;

    // Storage array, contents need no reset
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= rx_data;
    end

    // Pointers, count, flags and control registers
    always_ff @(posedge clk or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_irq_en <= 1'b0;
            r_thr    <= 8'h01;
            r_irq    <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push)
                    r_wptr <= r_wptr + AW'(1);
                if (w_pop)
                    r_rptr <= r_rptr + AW'(1);
            end
            r_count  <= w_count_nx;
            r_ovf    <= w_ovf_nx;
            r_irq_en <= w_irq_en_nx;
            r_thr    <= w_thr_nx;
            r_irq    <= w_irq_nx;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus random traffic,
// all checked against a queue-based model of the register behaviour.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        APB_PRESETn = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [3:0]  pstb = '0;
    logic        pready;
    logic        perr;
    logic        rx_strobe = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        irq;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  q[$];
    logic        m_ovf = 1'b0;
    logic        m_irqen = 1'b0;
    int          m_thr = 1;
    logic        m_irq = 1'b0;

    logic [31:0] last_rd;
    logic        s_irq;
    logic        s_perr;

    uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .APB_PRESETn(APB_PRESETn), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .psel(psel),
        .penable(penable), .pwrite(pwrite), .pstb(pstb),
        .pready(pready), .perr(perr), .rx_strobe(rx_strobe),
        .rx_data(rx_data), .irq(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return 32'(q.size()) + ((q.size() == 0) ? 32'h200 : 32'h0)
             + ((q.size() == DEPTH) ? 32'h400 : 32'h0)
             + (m_ovf ? 32'h800 : 32'h0) + (m_irq ? 32'h1000 : 32'h0);
    endfunction

    task automatic m_reset();
        q.delete();
        m_ovf = 1'b0;
        m_irqen = 1'b0;
        m_thr = 1;
        m_irq = 1'b0;
    endtask

    task automatic step(input logic s, input logic e, input logic w,
                        input logic [3:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input logic rx,
                        input logic [7:0] rd);
        logic        acc, err, pop, flush, full0;
        logic [31:0] exp;
        @(negedge clk);
        s_irq = irq;
        chk("irq", 32'(irq), 32'(m_irq));
        psel = s; penable = e; pwrite = w; paddr = {28'h0, a};
        pwdata = wd; pstb = st; rx_strobe = rx; rx_data = rd;
        #1;
        acc = s & e;
        err = acc & (!(a == 4'h0 || a == 4'h4 || a == 4'h8)
                     || (w && a == 4'h0));
        exp = 32'h0;
        if (acc && !w && !err) begin
            if (a == 4'h0)
                exp = (q.size() > 0) ? {24'h0, q[0]} : 32'h8000_0000;
            else if (a == 4'h4)
                exp = m_status();
            else
                exp = 32'(m_irqen) + 32'(m_thr * 256);
        end
        chk("pready", 32'(pready), 32'(acc));
        if (acc) begin
            s_perr = perr;
            chk("perr", 32'(perr), 32'(err));
            if (!w || err)
                chk("prdata", prdata, exp);
        end
        last_rd = prdata;
        @(posedge clk);
        full0 = (q.size() == DEPTH);
        pop   = acc && !w && a == 4'h0 && q.size() > 0;
        flush = acc && w && a == 4'h8 && st[2] && wd[16];
        if (acc && w && a == 4'h4 && st[1] && wd[11])
            m_ovf = 1'b0;
        if (acc && w && a == 4'h8) begin
            if (st[0]) m_irqen = wd[0];
            if (st[1]) m_thr = (wd[15:8] == 8'h0) ? 1 : int'(wd[15:8]);
        end
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (rx) begin
                if (!full0 || pop) q.push_back(rd);
                else m_ovf = 1'b1;
            end
        end
        m_irq = m_irqen && (q.size() >= m_thr || m_ovf);
    endtask

    task automatic apb_rd(input logic [3:0] a, input logic rx,
                          input logic [7:0] rd);
        step(1, 0, 0, a, 0, 0, 0, 0);
        step(1, 1, 0, a, 0, 0, rx, rd);
    endtask

    task automatic apb_wr(input logic [3:0] a, input logic [31:0] wd,
                          input logic [3:0] st, input logic rx,
                          input logic [7:0] rd);
        step(1, 0, 1, a, wd, st, 0, 0);
        step(1, 1, 1, a, wd, st, rx, rd);
    endtask

    task automatic push(input logic [7:0] b);
        step(0, 0, 0, 0, 0, 0, 1, b);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [3:0] bad_offs [6];
        bad_offs = '{4'hC, 4'h1, 4'h2, 4'h6, 4'hB, 4'hF};

        // reset held, an access in progress must not show through
        psel = 1'b1; penable = 1'b1; paddr = 32'h4;
        #12;
        chk("rst_pready", 32'(pready), 32'h0);
        chk("rst_prdata", prdata, 32'h0);
        paddr = 32'hC;
        #1;
        chk("rst_perr", 32'(perr), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        psel = 1'b0; penable = 1'b0; paddr = 32'h0;
        #9 APB_PRESETn = 1'b1;

        apb_rd(4'h4, 0, 0);
        chk("reset_status", last_rd, 32'h200);
        apb_rd(4'h8, 0, 0);
        chk("reset_ctrl", last_rd, 32'h100);

        // two bytes in, two out, then the empty marker
        push(8'h41);
        push(8'h42);
        apb_rd(4'h0, 0, 0);
        chk("r037_a", last_rd, 32'h41);
        apb_rd(4'h0, 0, 0);
        chk("r037_b", last_rd, 32'h42);
        apb_rd(4'h0, 0, 0);
        chk("r037_empty", last_rd, 32'h8000_0000);
        apb_rd(4'h4, 0, 0);
        chk("r037_status", last_rd, 32'h200);

        // overfill, drain, clear overflow
        for (int i = 0; i <= 16; i++) push(8'(i));
        apb_rd(4'h4, 0, 0);
        chk("r038_status", last_rd, 32'hC10);
        for (int i = 0; i < 16; i++) begin
            apb_rd(4'h0, 0, 0);
            chk("r038_data", last_rd, 32'(i));
        end
        apb_wr(4'h4, 32'h800, 4'b0010, 0, 0);
        apb_rd(4'h4, 0, 0);
        chk("r038_clr", last_rd, 32'h200);

        // full FIFO with coincident push and pop, across pointer wrap
        for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
        apb_rd(4'h0, 1, 8'hAA);
        chk("r039_head", last_rd, 32'h80);
        apb_rd(4'h4, 0, 0);
        chk("r039_status", last_rd, 32'h410);
        for (int i = 0; i < 40; i++) apb_rd(4'h0, 1, 8'($urandom));
        apb_rd(4'h4, 0, 0);
        chk("r039_after", last_rd, 32'h410);
        for (int i = 0; i < 16; i++) apb_rd(4'h0, 0, 0);

        // threshold interrupt
        apb_wr(4'h8, 32'h0301, 4'b0011, 0, 0);
        push(8'h01);
        push(8'h02);
        push(8'h03);
        chk("r040_pre", 32'(s_irq), 32'h0);
        idle();
        chk("r040_rise", 32'(s_irq), 32'h1);
        apb_rd(4'h0, 0, 0);
        idle();
        chk("r040_fall", 32'(s_irq), 32'h0);

        // flush with a coincident strobe
        apb_wr(4'h8, 32'h10000, 4'b0100, 1, 8'h55);
        apb_rd(4'h4, 0, 0);
        chk("r041_status", last_rd, 32'h200);
        apb_rd(4'h8, 0, 0);
        chk("r041_ctrl", last_rd & 32'h10001, 32'h1);

        // illegal accesses
        push(8'h77);
        apb_wr(4'h0, 32'h12, 4'hF, 0, 0);
        chk("r042_wr_perr", 32'(s_perr), 32'h1);
        apb_rd(4'hC, 0, 0);
        chk("r042_rd_perr", 32'(s_perr), 32'h1);
        chk("r042_rd_data", last_rd, 32'h0);
        foreach (bad_offs[i]) begin
            apb_wr(bad_offs[i], 32'hFFFF_FFFF, 4'hF, 0, 0);
            apb_rd(bad_offs[i], 0, 0);
        end
        apb_rd(4'h4, 0, 0);
        chk("r042_status", last_rd, 32'h001);
        apb_rd(4'h0, 0, 0);
        chk("r042_data", last_rd, 32'h77);

        // random traffic
        for (int n = 0; n < 500; n++) begin
            int k;
            logic [31:0] wd;
            logic rx;
            k  = $urandom_range(0, 9);
            rx = 1'($urandom);
            wd = $urandom;
            if (k <= 3) begin
                push(8'($urandom));
            end else if (k <= 5) begin
                apb_rd(4'h0, rx, 8'($urandom));
            end else if (k == 6) begin
                apb_rd(4'h4, rx, 8'($urandom));
            end else if (k == 7) begin
                apb_wr(4'h4, wd, 4'($urandom), rx, 8'($urandom));
            end else if (k == 8) begin
                wd[15:8] = 8'($urandom_range(0, 18));
                if ($urandom_range(0, 3) != 0) wd[16] = 1'b0;
                apb_wr(4'h8, wd, 4'($urandom), rx, 8'($urandom));
            end else begin
                apb_rd(bad_offs[$urandom_range(0, 5)], rx, 8'($urandom));
            end
        end

        // reset in the middle of a transfer
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8;
        pwdata = 32'h0301; pstb = 4'hF; rx_strobe = 1'b0;
        #2 APB_PRESETn = 1'b0;
        #1 penable = 1'b1;
        #1;
        chk("mid_pready", 32'(pready), 32'h0);
        chk("mid_perr", 32'(perr), 32'h0);
        chk("mid_prdata", prdata, 32'h0);
        chk("mid_irq", 32'(irq), 32'h0);
        @(negedge clk);
        psel = 1'b0; penable = 1'b0;
        #2 APB_PRESETn = 1'b1;
        m_reset();
        apb_rd(4'h8, 0, 0);
        chk("mid_ctrl", last_rd, 32'h100);
        apb_wr(4'h8, 32'h0501, 4'b0011, 0, 0);
        apb_rd(4'h8, 0, 0);
        chk("mid_ctrl_wr", last_rd, 32'h501);
        idle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
